// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - ALU and memory handshake between control unit and datapath
interface multicycle_control_unit_if;
    logic [3:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_bcond;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       mem_ready;

    modport master (
        output alu_op, alu_src_a, alu_src_b, mem_read, mem_write, i_or_d,
        input  alu_bcond, mem_ready
    );

    modport slave (
        input  alu_op, alu_src_a, alu_src_b, mem_read, mem_write, i_or_d,
        output alu_bcond, mem_ready
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle RV32I sequencer driving ALU, memory and write-back strobes
module multicycle_control_unit #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    multicycle_control_unit_if.master bus,
    output logic                 alu_out_write,
    output logic                 pc_write,
    output logic [1:0]           pc_source,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic [1:0]           wb_sel,
    output logic                 is_halted,
    output logic [CNT_WIDTH-1:0] inst_count
);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_XOR = 4'd2, OP_OR  = 4'd3,
                           OP_AND = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_BEQ = 4'd7,
                           OP_BNE = 4'd8, OP_BLT = 4'd9, OP_BGE = 4'd10, OP_ECA = 4'd11;

    localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011, OPC_LD = 7'b0000011,
                           OPC_ST = 7'b0100011, OPC_BR = 7'b1100011, OPC_JAL = 7'b1101111,
                           OPC_JALR = 7'b1100111, OPC_SYS = 7'b1110011;

    typedef enum logic [3:0] {
        S_IF, S_ID, S_EX_ALU, S_WB_ALU, S_EX_ADDR, S_MEM_RD, S_WB_MEM,
        S_MEM_WR, S_EX_BR, S_EX_JAL, S_EX_JALR, S_EX_ECALL, S_HALT
    } state_t;

    state_t state, next_state;
    logic   retire;
    logic   pc_write_raw, ir_write_raw, reg_write_raw, mem_write_raw, alu_out_write_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IF;
            inst_count <= '0;
        end else begin
            state <= next_state;
            if (retire)
                inst_count <= inst_count + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        next_state        = state;
        retire            = 1'b0;
        bus.alu_op        = OP_ADD;
        bus.alu_src_a     = 2'd0;
        bus.alu_src_b     = 2'd0;
        bus.mem_read      = 1'b0;
        mem_write_raw     = 1'b0;
        bus.i_or_d        = 1'b0;
        alu_out_write_raw = 1'b0;
        pc_write_raw      = 1'b0;
        pc_source         = 2'd0;
        ir_write_raw      = 1'b0;
        reg_write_raw     = 1'b0;
        wb_sel            = 2'd0;

        case (state)
            S_IF: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'd2;
                if (bus.mem_ready) begin
                    ir_write_raw = 1'b1;
                    pc_write_raw = 1'b1;
                    next_state   = S_ID;
                end
            end
            S_ID: begin
                // Precompute old_pc + imm so branch/JAL can redirect from ALUOut later.
                bus.alu_src_a     = 2'd1;
                bus.alu_src_b     = 2'd1;
                alu_out_write_raw = 1'b1;
                case (opcode)
                    OPC_R, OPC_I:    next_state = S_EX_ALU;
                    OPC_LD, OPC_ST:  next_state = S_EX_ADDR;
                    OPC_BR:          next_state = S_EX_BR;
                    OPC_JAL:         next_state = S_EX_JAL;
                    OPC_JALR:        next_state = S_EX_JALR;
                    OPC_SYS:         next_state = S_EX_ECALL;
                    default:         next_state = S_IF;
                endcase
            end
            S_EX_ALU: begin
                bus.alu_src_a     = 2'd2;
                bus.alu_src_b     = (opcode == OPC_R) ? 2'd0 : 2'd1;
                alu_out_write_raw = 1'b1;
                next_state        = S_WB_ALU;
                case (funct3)
                    3'b000: bus.alu_op = (opcode == OPC_R && funct7_5) ? OP_SUB : OP_ADD;
                    3'b001: bus.alu_op = OP_SLL;
                    3'b100: bus.alu_op = OP_XOR;
                    3'b101: bus.alu_op = OP_SRL;
                    3'b110: bus.alu_op = OP_OR;
                    3'b111: bus.alu_op = OP_AND;
                    default: bus.alu_op = OP_ADD;
                endcase
                if (funct3 == 3'b010 || funct3 == 3'b011 || (funct3 == 3'b101 && funct7_5)) begin
                    alu_out_write_raw = 1'b0;
                    next_state        = S_IF;
                end
            end
            S_WB_ALU: begin
                reg_write_raw = 1'b1;
                retire        = 1'b1;
                next_state    = S_IF;
            end
            S_EX_ADDR: begin
                bus.alu_src_a     = 2'd2;
                bus.alu_src_b     = 2'd1;
                alu_out_write_raw = 1'b1;
                next_state        = (opcode == OPC_LD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                bus.i_or_d   = 1'b1;
                bus.mem_read = 1'b1;
                if (bus.mem_ready)
                    next_state = S_WB_MEM;
            end
            S_WB_MEM: begin
                reg_write_raw = 1'b1;
                wb_sel        = 2'd1;
                retire        = 1'b1;
                next_state    = S_IF;
            end
            S_MEM_WR: begin
                bus.i_or_d    = 1'b1;
                mem_write_raw = 1'b1;
                if (bus.mem_ready) begin
                    retire     = 1'b1;
                    next_state = S_IF;
                end
            end
            S_EX_BR: begin
                bus.alu_src_a = 2'd2;
                pc_source     = 2'd1;
                next_state    = S_IF;
                retire        = 1'b1;
                case (funct3)
                    3'b000: bus.alu_op = OP_BEQ;
                    3'b001: bus.alu_op = OP_BNE;
                    3'b100: bus.alu_op = OP_BLT;
                    3'b101: bus.alu_op = OP_BGE;
                    default: retire    = 1'b0;
                endcase
                pc_write_raw = retire & bus.alu_bcond;
            end
            S_EX_JAL: begin
                reg_write_raw = 1'b1;
                wb_sel        = 2'd2;
                pc_write_raw  = 1'b1;
                pc_source     = 2'd1;
                retire        = 1'b1;
                next_state    = S_IF;
            end
            S_EX_JALR: begin
                bus.alu_src_a = 2'd2;
                bus.alu_src_b = 2'd1;
                reg_write_raw = 1'b1;
                wb_sel        = 2'd2;
                pc_write_raw  = 1'b1;
                pc_source     = 2'd2;
                retire        = 1'b1;
                next_state    = S_IF;
            end
            S_EX_ECALL: begin
                bus.alu_src_a = 2'd2;
                bus.alu_op    = OP_ECA;
                retire        = 1'b1;
                next_state    = bus.alu_bcond ? S_HALT : S_IF;
            end
            S_HALT: next_state = S_HALT;
            default: next_state = S_IF;
        endcase
    end

    // Architectural strobes are suppressed while reset is held so nothing commits mid-reset.
    assign pc_write      = pc_write_raw      & ~reset;
    assign ir_write      = ir_write_raw      & ~reset;
    assign reg_write     = reg_write_raw     & ~reset;
    assign bus.mem_write = mem_write_raw     & ~reset;
    assign alu_out_write = alu_out_write_raw & ~reset;
    assign is_halted     = (state == S_HALT);
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - randomized self-checking bench with instruction-level reference model
module tb_multicycle_control_unit;
    localparam int CW = 4;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, XOR = 4'd2, OR = 4'd3, AND = 4'd4,
                           SLL = 4'd5, SRL = 4'd6, BEQ = 4'd7, BNE = 4'd8, BLT = 4'd9,
                           BGE = 4'd10, ECA = 4'd11;
    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011,
                           BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, SYS = 7'b1110011;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          funct7_5;
    logic          alu_out_write, pc_write, ir_write, reg_write, is_halted;
    logic [1:0]    pc_source, wb_sel;
    logic [CW-1:0] inst_count;

    multicycle_control_unit_if bus ();

    multicycle_control_unit #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .bus(bus), .alu_out_write(alu_out_write), .pc_write(pc_write), .pc_source(pc_source),
        .ir_write(ir_write), .reg_write(reg_write), .wb_sel(wb_sel), .is_halted(is_halted),
        .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int model_count = 0;

    typedef struct {
        int       lat;
        int       mem;     // 0 none, 1 load, 2 store
        bit       retire;
        int       rw;
        int       pcw;
        int       aow;
        logic [1:0] wb;
        logic [1:0] psrc;
        bit       chk;
        logic [3:0] op;
        logic [1:0] a;
        logic [1:0] b;
    } exp_t;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                   input logic bc);
        exp_t e;
        e = '{lat: 2, mem: 0, retire: 0, rw: 0, pcw: 0, aow: 1, wb: 2'd0, psrc: 2'd0,
              chk: 0, op: ADD, a: 2'd0, b: 2'd0};
        case (opc)
            R, I: begin
                bit legal;
                e.chk = 1; e.a = 2; e.b = (opc == R) ? 2'd0 : 2'd1; e.lat = 3;
                legal = 1;
                case (f3)
                    3'd0: e.op = (opc == R && f7) ? SUB : ADD;
                    3'd1: e.op = SLL;
                    3'd4: e.op = XOR;
                    3'd5: begin e.op = SRL; legal = !f7; end
                    3'd6: e.op = OR;
                    3'd7: e.op = AND;
                    default: legal = 0;
                endcase
                if (legal) begin e.lat = 4; e.retire = 1; e.rw = 1; e.aow = 2; end
                else e.chk = (f3 == 3'd5);
            end
            LD: begin e.lat = 5; e.mem = 1; e.retire = 1; e.rw = 1; e.wb = 1; e.aow = 2;
                      e.chk = 1; e.a = 2; e.b = 1; e.op = ADD; end
            ST: begin e.lat = 4; e.mem = 2; e.retire = 1; e.aow = 2;
                      e.chk = 1; e.a = 2; e.b = 1; e.op = ADD; end
            BR: begin
                e.lat = 3; e.chk = 1; e.a = 2; e.b = 0; e.psrc = 1;
                case (f3)
                    3'd0: e.op = BEQ;
                    3'd1: e.op = BNE;
                    3'd4: e.op = BLT;
                    3'd5: e.op = BGE;
                    default: e.op = ADD;
                endcase
                e.retire = (f3 == 0 || f3 == 1 || f3 == 4 || f3 == 5);
                e.pcw = (e.retire && bc) ? 1 : 0;
            end
            JAL:  begin e.lat = 3; e.retire = 1; e.rw = 1; e.wb = 2; e.pcw = 1; e.psrc = 1;
                        e.chk = 1; e.a = 0; e.b = 0; e.op = ADD; end
            JALR: begin e.lat = 3; e.retire = 1; e.rw = 1; e.wb = 2; e.pcw = 1; e.psrc = 2;
                        e.chk = 1; e.a = 2; e.b = 1; e.op = ADD; end
            SYS:  begin e.lat = 3; e.retire = 1; e.chk = 1; e.a = 2; e.b = 0; e.op = ECA; end
            default: ;
        endcase
        return e;
    endfunction

    // Runs one instruction from IF back to IF; w_if / w_mem are the not-ready cycles injected.
    task automatic run_inst(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                            input logic bc, input int w_if, input int w_mem, output int lat);
        exp_t e;
        int   rw_n = 0, pcw_n = 0, aow_n = 0, mw_n = 0, mr_n = 0, irw_n = 0;
        logic [1:0] wb_seen = 0, psrc_seen = 0;
        logic [3:0] op_seen = 0;
        logic [1:0] a_seen = 0, b_seen = 0;
        bit   done = 0;
        e = model(opc, f3, f7, bc);
        if (e.mem == 0) w_mem = 0;
        opcode = opc; funct3 = f3; funct7_5 = f7; bus.alu_bcond = bc;
        lat = -1;
        for (int k = 0; k < 60 && !done; k++) begin
            bus.mem_ready = !(k < w_if || (e.mem != 0 && k >= w_if + 3 && k < w_if + 3 + w_mem));
            #1;
            if (k > w_if && bus.mem_read && !bus.i_or_d) begin
                lat = k;
                done = 1;
            end else begin
                rw_n  += reg_write;
                pcw_n += (pc_write && k > w_if) ? 1 : 0;
                aow_n += alu_out_write;
                mw_n  += bus.mem_write;
                mr_n  += bus.mem_read;
                irw_n += ir_write;
                if (reg_write) wb_seen = wb_sel;
                if (pc_write && k > w_if) psrc_seen = pc_source;
                if (k == w_if + 2) begin
                    op_seen = bus.alu_op; a_seen = bus.alu_src_a; b_seen = bus.alu_src_b;
                end
                tick();
            end
        end
        if (e.retire) model_count = (model_count + 1) % (1 << CW);
        check("latency", lat, e.lat + w_if + w_mem);
        check("reg_write_cycles", rw_n, e.rw);
        check("pc_write_cycles", pcw_n, e.pcw);
        check("alu_out_write_cycles", aow_n, e.aow);
        check("mem_write_cycles", mw_n, (e.mem == 2) ? w_mem + 1 : 0);
        check("mem_read_cycles", mr_n, w_if + 1 + ((e.mem == 1) ? w_mem + 1 : 0));
        check("ir_write_cycles", irw_n, 1);
        if (e.rw != 0) check("wb_sel", wb_seen, e.wb);
        if (e.pcw != 0) check("pc_source", psrc_seen, e.psrc);
        if (e.chk) begin
            check("exec_alu_op", op_seen, e.op);
            check("exec_src_a", a_seen, e.a);
            check("exec_src_b", b_seen, e.b);
        end
        check("inst_count", inst_count, model_count);
    endtask

    initial begin
        int lat;
        logic [6:0] opcs [9];
        opcs = '{R, I, LD, ST, BR, JAL, JALR, SYS, 7'b0001111};

        reset = 1'b1; opcode = R; funct3 = 0; funct7_5 = 0;
        bus.mem_ready = 1'b1; bus.alu_bcond = 1'b0;
        #1;
        check("reset_strobes", {pc_write, ir_write, reg_write, bus.mem_write, alu_out_write}, 5'b0);
        tick(); tick();
        reset = 1'b0;
        #1;
        check("reset_inst_count", inst_count, 0);
        check("reset_is_halted", is_halted, 0);
        check("reset_in_fetch", {bus.mem_read, bus.i_or_d}, 2'b10);

        run_inst(R, 3'b000, 1'b0, 1'b0, 0, 0, lat);
        check("add_latency_4", lat, 4);
        run_inst(LD, 3'b010, 1'b0, 1'b0, 0, 3, lat);
        check("lw_latency_8", lat, 8);
        run_inst(BR, 3'b100, 1'b0, 1'b1, 0, 0, lat);
        run_inst(BR, 3'b100, 1'b0, 1'b0, 0, 0, lat);
        run_inst(I, 3'b010, 1'b0, 1'b0, 0, 0, lat);
        check("slti_latency_3", lat, 3);
        run_inst(ST, 3'b010, 1'b0, 1'b0, 1, 2, lat);
        run_inst(JAL, 3'b000, 1'b0, 1'b0, 0, 0, lat);
        run_inst(JALR, 3'b000, 1'b0, 1'b0, 2, 0, lat);
        run_inst(R, 3'b101, 1'b1, 1'b0, 0, 0, lat);
        run_inst(R, 3'b000, 1'b1, 1'b0, 0, 0, lat);
        run_inst(I, 3'b000, 1'b1, 1'b0, 0, 0, lat);

        for (int n = 0; n < 80; n++) begin
            logic [6:0] o;
            logic       bc;
            o  = opcs[$urandom_range(0, 8)];
            bc = (o == SYS) ? 1'b0 : 1'($urandom_range(0, 1));
            run_inst(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), bc,
                     $urandom_range(0, 2), $urandom_range(0, 3), lat);
        end

        // halting ecall
        opcode = SYS; funct3 = 0; funct7_5 = 0; bus.alu_bcond = 1'b1; bus.mem_ready = 1'b1;
        tick(); tick();
        check("ecall_op", bus.alu_op, ECA);
        tick();
        bus.alu_bcond = 1'b0;
        model_count = (model_count + 1) % (1 << CW);
        check("halt_inst_count", inst_count, model_count);
        for (int c = 0; c < 20; c++) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            #1;
            check("halt_state", {is_halted, pc_write, ir_write, reg_write, bus.mem_write,
                                 bus.mem_read, alu_out_write}, 7'b1000000);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        model_count = 0;
        check("post_halt_reset", {is_halted, bus.mem_read, bus.i_or_d}, 3'b010);
        check("post_halt_count", inst_count, 0);

        // reset during store access
        run_inst(R, 3'b111, 1'b0, 1'b0, 0, 0, lat);
        opcode = ST; funct3 = 3'b010;
        tick(); tick(); tick();
        bus.mem_ready = 1'b0;
        #1;
        check("mem_wr_active", {bus.mem_write, bus.i_or_d}, 2'b11);
        reset = 1'b1;
        #1;
        check("mem_wr_reset_strobes",
              {bus.mem_write, pc_write, ir_write, reg_write, alu_out_write}, 5'b0);
        tick();
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        model_count = 0;
        check("mem_wr_reset_fetch", {bus.mem_read, bus.i_or_d, bus.mem_write}, 3'b100);
        check("mem_wr_reset_count", inst_count, 0);
        run_inst(BR, 3'b000, 1'b0, 1'b1, 0, 0, lat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
